packetizer_n: RTL and testbench

Multi-flit packetizer. Accepts one wide data word plus destination on a valid/ready input port, splits it into a head flit and as many body/tail flits as needed, and emits them one per cycle on a flit-wide valid/ready NoC port with valid/head/tail/VC/dest headers. Sits between a module's output translator and a NoC router input. It replaces single-flit packetizing wherever WIDTH_IN exceeds one flit's payload.

---
 rtl/packetizer_n.sv | 127 ++++++++++++
 tb/tb_packetizer_n.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/packetizer_n.sv
// packetizer_n: splits one wide input word into head/body/tail NoC flits, one per cycle.
// Optional build macro PACKETIZER_N_VC_ROTATE_EN rotates the stamped VC after every packet.
module packetizer_n #(
   parameter int ADDRESS_WIDTH    = 4,
   parameter int VC_ADDRESS_WIDTH = 1,
   parameter int WIDTH_IN         = 64,
   parameter int WIDTH_OUT        = 36,
   parameter int ASSIGNED_VC      = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH_IN-1:0]      i_data_in,
   input  logic                     i_valid_in,
   input  logic [ADDRESS_WIDTH-1:0] i_dest_in,
   output logic                     i_ready_out,
   output logic [WIDTH_OUT-1:0]     o_data_out,
   output logic                     o_valid_out,
   input  logic                     o_ready_in
);

   localparam int H         = WIDTH_OUT - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
   localparam int B         = WIDTH_OUT - 3 - VC_ADDRESS_WIDTH;
   localparam int EXTRA     = (WIDTH_IN > H) ? (WIDTH_IN - H) : 0;
   localparam int NUM_FLITS = 1 + (EXTRA + B - 1) / B;
   localparam int TOT_W     = H + (NUM_FLITS - 1) * B;
   localparam int CNT_W     = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_FLITS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                         state_q, state_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [TOT_W-1:0]               data_p0;
   logic [ADDRESS_WIDTH-1:0]       dest_p0;
   logic [VC_ADDRESS_WIDTH-1:0]    vc;
   logic                           last, in_fire, tail_fire;
   logic [H-1:0]                   head_pl;
   logic [B-1:0]                   body_pl;
   logic [WIDTH_OUT-1:0]           flit;

   // Packs the word against the MSB end so every flit slice lines up on a B boundary.
   function automatic logic [TOT_W-1:0] left_justify(input logic [WIDTH_IN-1:0] d);
      return TOT_W'(d) << (TOT_W - WIDTH_IN);
   endfunction

   assign last      = (cnt_q == LAST);
   assign tail_fire = (state_q == SEND) & last & o_ready_in;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      i_ready_out = (state_q == IDLE) | tail_fire;
      in_fire     = i_valid_in & i_ready_out;
      case (state_q)
         IDLE: begin
            if (in_fire) begin
               state_d = SEND;
               cnt_d   = '0;
            end
         end
         SEND: begin
            if (o_ready_in) begin
               if (last) begin
                  cnt_d   = '0;
                  state_d = in_fire ? SEND : IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Capture stage: payload and destination only, so no reset.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         data_p0 <= left_justify(i_data_in);
         dest_p0 <= i_dest_in;
      end
   end

`ifdef PACKETIZER_N_VC_ROTATE_EN
   logic [VC_ADDRESS_WIDTH-1:0] vc_q;

   // Changes only on a tail handshake, so every flit of a packet sees one value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         vc_q <= VC_ADDRESS_WIDTH'(ASSIGNED_VC);
      else if (tail_fire) vc_q <= vc_q + VC_ADDRESS_WIDTH'(1);
   end
   assign vc = vc_q;
`else
   assign vc = VC_ADDRESS_WIDTH'(ASSIGNED_VC);
`endif

   assign head_pl = data_p0[TOT_W-1 -: H];

   if (NUM_FLITS > 1) begin : g_body
      logic [TOT_W-1:0] body_sh;
      always_comb body_sh = data_p0 << ((cnt_q == '0) ? 0 : (H + (int'(cnt_q) - 1) * B));
      assign body_pl = body_sh[TOT_W-1 -: B];
   end else begin : g_nobody
      assign body_pl = '0;
   end

   always_comb begin
      flit = '0;
      if (state_q == SEND) begin
         if (cnt_q == '0) flit = {1'b1, 1'b1, last, vc, dest_p0, head_pl};
         else             flit = {1'b1, 1'b0, last, vc, body_pl};
      end
   end

   assign o_data_out  = flit;
   assign o_valid_out = (state_q == SEND);

endmodule

// File: tb/tb_packetizer_n.sv
// tb_packetizer_n: directed bench for packetizer_n with a flit scoreboard on the default instance.
module tb_packetizer_n;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // default configuration
   logic [63:0] a_data;
   logic        a_valid;
   logic [3:0]  a_dest;
   logic        a_ready;
   logic [35:0] a_odata;
   logic        a_ovalid;
   logic        a_oready;

   // single-flit configuration
   logic [11:0] b_data;
   logic        b_valid;
   logic [3:0]  b_dest;
   logic        b_ready;
   logic [35:0] b_odata;
   logic        b_ovalid;
   logic        b_oready;

   // ASSIGNED_VC = 1 configuration
   logic [63:0] c_data;
   logic        c_valid;
   logic [3:0]  c_dest;
   logic        c_ready;
   logic [35:0] c_odata;
   logic        c_ovalid;
   logic        c_oready;

   packetizer_n u_a (
      .clk(clk), .rst_n(rst_n), .i_data_in(a_data), .i_valid_in(a_valid), .i_dest_in(a_dest),
      .i_ready_out(a_ready), .o_data_out(a_odata), .o_valid_out(a_ovalid), .o_ready_in(a_oready));

   packetizer_n #(.WIDTH_IN(12)) u_b (
      .clk(clk), .rst_n(rst_n), .i_data_in(b_data), .i_valid_in(b_valid), .i_dest_in(b_dest),
      .i_ready_out(b_ready), .o_data_out(b_odata), .o_valid_out(b_ovalid), .o_ready_in(b_oready));

   packetizer_n #(.ASSIGNED_VC(1)) u_c (
      .clk(clk), .rst_n(rst_n), .i_data_in(c_data), .i_valid_in(c_valid), .i_dest_in(c_dest),
      .i_ready_out(c_ready), .o_data_out(c_odata), .o_valid_out(c_ovalid), .o_ready_in(c_oready));

   int tests = 0;
   int fails = 0;
   logic [35:0] exp_q[$];

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected flit k of a 64-bit packet in a 36-bit flit (H=28, B=32).
   function automatic logic [35:0] flit64(input logic [63:0] d, input logic [3:0] dst,
                                          input logic vcb, input int k);
      case (k)
         0:       return {1'b1, 1'b1, 1'b0, vcb, dst, d[63:36]};
         1:       return {1'b1, 1'b0, 1'b0, vcb, d[35:4]};
         default: return {1'b1, 1'b0, 1'b1, vcb, d[3:0], 28'h0};
      endcase
   endfunction

   always @(negedge clk) begin
      if (a_ovalid && a_oready) begin
         if (exp_q.size() == 0) check("unexpected_flit", a_odata, 36'h0);
         else                   check("flit", a_odata, exp_q.pop_front());
      end else if (!a_ovalid) begin
         check("idle_data_zero", a_odata, 36'h0);
      end
   end

   task automatic send_a(input logic [63:0] d, input logic [3:0] dst, output int waits);
      a_data  = d;
      a_dest  = dst;
      a_valid = 1'b1;
      for (int k = 0; k < 3; k++) exp_q.push_back(flit64(d, dst, 1'b0, k));
      waits = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (a_ready) break;
         waits++;
      end
      if (waits >= 20) check("accept_timeout", 36'(a_ready), 36'd1);
      @(posedge clk);
      #1 a_valid = 1'b0;
   endtask

   task automatic drain;
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
      check("drain", 36'(exp_q.size()), 36'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] d1, d2, d3;
      logic        ev;
      int          w;

      rst_n = 1'b0;
      a_data = '0; a_valid = 1'b0; a_dest = '0; a_oready = 1'b1;
      b_data = '0; b_valid = 1'b0; b_dest = '0; b_oready = 1'b1;
      c_data = '0; c_valid = 1'b0; c_dest = '0; c_oready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 36'(a_ovalid), 36'd0);
      check("rst_data", a_odata, 36'h0);
      check("rst_ready", 36'(a_ready), 36'd1);
      check("rst_ready_b", 36'(b_ready), 36'd1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single packet, latency and valid drop
      send_a(64'hFEDC_BA98_7654_3210, 4'h5, w);
      check("idle_accept_wait", 36'(w), 36'd0);
      @(negedge clk);
      check("head_latency", a_odata, 36'({1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 28'hFEDCBA9}));
      drain();
      @(negedge clk);
      check("valid_drop", 36'(a_ovalid), 36'd0);

      // back-to-back packets
      d1 = {$urandom(), $urandom()};
      d2 = {$urandom(), $urandom()};
      @(posedge clk);
      #1;
      send_a(d1, 4'hA, w);
      send_a(d2, 4'h3, w);
      check("b2b_ready_wait", 36'(w), 36'd2);
      @(negedge clk);
      check("b2b_no_gap", a_odata, flit64(d2, 4'h3, 1'b0, 0));
      drain();
      @(negedge clk);
      check("b2b_valid_drop", 36'(a_ovalid), 36'd0);

      // backpressure on the body flit
      d3 = {$urandom(), $urandom()};
      @(posedge clk);
      #1;
      send_a(d3, 4'h7, w);
      @(posedge clk);
      #1 a_oready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold", a_odata, flit64(d3, 4'h7, 1'b0, 1));
         check("bp_ready", 36'(a_ready), 36'd0);
      end
      @(posedge clk);
      #1 a_oready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_tail", a_odata, flit64(d3, 4'h7, 1'b0, 2));
      drain();

      // reset mid-body
      @(posedge clk);
      #1;
      send_a(64'h0123_4567_89AB_CDEF, 4'h9, w);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 36'(a_ovalid), 36'd0);
      check("mid_rst_data", a_odata, 36'h0);
      exp_q.delete();
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 36'(a_ready), 36'd1);
      @(posedge clk);
      #1;
      send_a(64'h1122_3344_5566_7788, 4'hC, w);
      @(negedge clk);
      check("post_rst_head", a_odata, flit64(64'h1122_3344_5566_7788, 4'hC, 1'b0, 0));
      drain();

      // single-flit configuration
      @(posedge clk);
      #1;
      b_data = 12'hABC; b_dest = 4'h3; b_valid = 1'b1;
      @(posedge clk);
      #1 b_valid = 1'b0;
      @(negedge clk);
      check("single_flit", b_odata, {1'b1, 1'b1, 1'b1, 1'b0, 4'h3, 12'hABC, 16'h0});
      @(negedge clk);
      check("single_drop", 36'(b_ovalid), 36'd0);

      // VC stamping on the ASSIGNED_VC=1 instance
      for (int p = 0; p < 3; p++) begin
`ifdef PACKETIZER_N_VC_ROTATE_EN
         ev = (p % 2 == 0) ? 1'b1 : 1'b0;
`else
         ev = 1'b1;
`endif
         d1 = {$urandom(), $urandom()};
         @(posedge clk);
         #1;
         check("vc_idle_ready", 36'(c_ready), 36'd1);
         c_data = d1; c_dest = 4'(p + 1); c_valid = 1'b1;
         @(posedge clk);
         #1 c_valid = 1'b0;
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("vc_flit", c_odata, flit64(d1, 4'(p + 1), ev, k));
         end
      end
      @(negedge clk);
      check("vc_valid_drop", 36'(c_ovalid), 36'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
